deser_queue: RTL and testbench

Parametrised serial-to-parallel front end with integrated word queue, replacing the separate deserializer, FIFO, clock divider and occupancy checker with one single-clock block. Bits arrive on `data_in` qualified by `write_in` and a divided bit strobe. They are packed MSB-first into `DATA_W`-bit words and pushed into a `DEPTH`-entry circular queue, which the consumer drains with `dequeue_in`. Backpressure is generated internally from queue occupancy, so no external ack path is needed.

---
 rtl/deser_queue.sv | 176 +++++++++++++++++
 tb/tb_deser_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/deser_queue.sv
// rtl/deser_queue.sv - serial-to-parallel deserializer feeding a circular word queue with occupancy backpressure
// Optional feature macro: DESER_PARITY_EN (one even-parity bit per word; mismatching words are dropped).
module deser_queue #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int BIT_DIV = 10,
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock1M,
    input  logic              reset,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              dequeue_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              status_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              parity_err_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {S_COLLECT = 2'd0, S_PARITY = 2'd1, S_HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_COLLECT = 2'd0, S_HOLD = 2'd2} state_t;
`endif

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                tick;
    logic                full;
    logic                empty;
    logic                pop;
    logic                push;

    assign tick  = (div_q == DIV_W'(BIT_DIV - 1));
    assign full  = (cnt_q == LEN_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = dequeue_in && !empty;
    // A granted pop frees a slot in the same edge, so a full queue still accepts the held word.
    assign push  = (state_q == S_HOLD) && (!full || pop);

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            state_q  <= S_COLLECT;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

`ifdef DESER_PARITY_EN
    logic perr_q, perr_d;

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err_out = perr_q;
`else
    assign parity_err_out = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`ifdef DESER_PARITY_EN
        perr_d   = 1'b0;
`endif
        case (state_q)
            S_COLLECT: begin
                if (tick && write_in) begin
                    shreg_d  = {shreg_q[DATA_W-2:0], data_in};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef DESER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_HOLD;
`endif
                    end
                end
            end
`ifdef DESER_PARITY_EN
            S_PARITY: begin
                // Even parity: the parity bit equals the XOR of the data bits.
                if (tick && write_in) begin
                    if (data_in == ^shreg_q) begin
                        state_d = S_HOLD;
                    end else begin
                        perr_d   = 1'b1;
                        state_d  = S_COLLECT;
                        bitcnt_d = '0;
                    end
                end
            end
`endif
            S_HOLD: begin
                if (push) begin
                    state_d  = S_COLLECT;
                    bitcnt_d = '0;
                end
            end
            default: begin
                state_d  = S_COLLECT;
                bitcnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= pop;
            if (push) begin
                mem_q[wr_ptr_q] <= shreg_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                data_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + LEN_W'(1);
                2'b01:   cnt_q <= cnt_q - LEN_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign status_out = (state_q != S_HOLD);
    assign len_out    = cnt_q;
    assign full_out   = full;
    assign empty_out  = empty;

endmodule

// File: tb/tb_deser_queue.sv
// tb/tb_deser_queue.sv - directed self-checking bench for deser_queue (build with +define+DESER_PARITY_EN for parity)
module tb_deser_queue;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int BIT_DIV = 10;
    localparam int LEN_W   = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              data_in;
    logic              write_in;
    logic              dequeue_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              status_out;
    logic [LEN_W-1:0]  len_out;
    logic              full_out;
    logic              empty_out;
    logic              parity_err_out;

    int                asserts  = 0;
    int                failures = 0;
    logic [7:0]        got_q[$];
    int                perr_cnt = 0;
    int                max_len  = 0;

    deser_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BIT_DIV(BIT_DIV)) dut (
        .clock1M        (clk),
        .reset          (rst_n),
        .data_in        (data_in),
        .write_in       (write_in),
        .dequeue_in     (dequeue_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .status_out     (status_out),
        .len_out        (len_out),
        .full_out       (full_out),
        .empty_out      (empty_out),
        .parity_err_out (parity_err_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out) got_q.push_back(data_out);
        if (parity_err_out) perr_cnt++;
        if (int'(len_out) > max_len) max_len = int'(len_out);
    end

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        asserts++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each bit is held for exactly BIT_DIV edges, so exactly one strobe falls inside it.
    task automatic send_bit(input logic b);
        data_in  = b;
        write_in = 1'b1;
        wait_cycles(BIT_DIV);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef DESER_PARITY_EN
        send_bit(^w);
`endif
        write_in = 1'b0;
        wait_cycles(2);
    endtask

    task automatic pop_check(input string tag, input logic exp_valid, input logic [7:0] exp_data,
                             input int exp_len);
        dequeue_in = 1'b1;
        wait_cycles(1);
        dequeue_in = 1'b0;
        check_eq({tag, "_valid"}, 32'(valid_out), 32'(exp_valid));
        check_eq({tag, "_data"}, 32'(data_out), 32'(exp_data));
        check_eq({tag, "_len"}, 32'(len_out), 32'(exp_len));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data"}, 32'(data_out), 32'h0);
        check_eq({tag, "_valid"}, 32'(valid_out), 32'h0);
        check_eq({tag, "_status"}, 32'(status_out), 32'h1);
        check_eq({tag, "_len"}, 32'(len_out), 32'h0);
        check_eq({tag, "_full"}, 32'(full_out), 32'h0);
        check_eq({tag, "_empty"}, 32'(empty_out), 32'h1);
        check_eq({tag, "_perr"}, 32'(parity_err_out), 32'h0);
    endtask

    initial begin
        logic [7:0] exp_stream [4];
        exp_stream = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n = 1'b0; data_in = 1'b0; write_in = 1'b0; dequeue_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        wait_cycles(1);
        check_reset_outputs("post_rst");

        // Single word 0xA5 then one pop
        send_word(8'hA5);
        check_eq("a5_len", 32'(len_out), 32'd1);
        check_eq("a5_empty", 32'(empty_out), 32'd0);
        pop_check("a5_pop", 1'b1, 8'hA5, 0);
        check_eq("a5_empty_after", 32'(empty_out), 32'd1);
        wait_cycles(1);
        check_eq("a5_valid_once", 32'(valid_out), 32'd0);

        // Fill the queue, then hold a 9th word
        for (int i = 1; i <= 8; i++) send_word(8'(i));
        check_eq("fill_len", 32'(len_out), 32'd8);
        send_word(8'h09);
        check_eq("full_flag", 32'(full_out), 32'd1);
        check_eq("hold_status", 32'(status_out), 32'd0);
        check_eq("hold_len", 32'(len_out), 32'd8);
        wait_cycles(5);
        check_eq("hold_persist", 32'(status_out), 32'd0);
        pop_check("free_pop", 1'b1, 8'h01, 8);
        check_eq("free_status", 32'(status_out), 32'd1);

        // Drain with pointer wrap; last two pops hit an empty queue
        for (int i = 0; i < 8; i++) pop_check($sformatf("drain%0d", i), 1'b1, 8'(i + 2), 7 - i);
        pop_check("drain_empty8", 1'b0, 8'h09, 0);
        pop_check("drain_empty9", 1'b0, 8'h09, 0);
        check_eq("drain_empty_flag", 32'(empty_out), 32'd1);

        // Continuous dequeue while streaming
        got_q.delete();
        max_len = 0;
        dequeue_in = 1'b1;
        for (int i = 0; i < 4; i++) send_word(exp_stream[i]);
        wait_cycles(3);
        dequeue_in = 1'b0;
        check_eq("stream_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("stream%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD,
                     32'(exp_stream[i]));
        check_eq("stream_max_len", 32'(max_len), 32'd1);
        check_eq("stream_len_end", 32'(len_out), 32'd0);

        // Reset mid-word with three words queued
        send_word(8'h5A);
        send_word(8'h6B);
        send_word(8'h7C);
        check_eq("pre_rst_len", 32'(len_out), 32'd3);
        for (int i = 7; i >= 3; i--) send_bit(1'(8'hC3 >> i));
        write_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        send_word(8'h3C);
        check_eq("post_rst_len", 32'(len_out), 32'd1);
        pop_check("post_rst_pop", 1'b1, 8'h3C, 0);

`ifdef DESER_PARITY_EN
        perr_cnt = 0;
        send_word(8'hA5);
        check_eq("par_ok_len", 32'(len_out), 32'd1);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA5 >> i));
        send_bit(1'b1);
        write_in = 1'b0;
        wait_cycles(3);
        check_eq("par_err_pulses", 32'(perr_cnt), 32'd1);
        check_eq("par_bad_len", 32'(len_out), 32'd1);
        check_eq("par_status", 32'(status_out), 32'd1);
        pop_check("par_pop", 1'b1, 8'hA5, 0);
`else
        check_eq("no_parity_pulses", 32'(perr_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
